// File: rtl/conv_pkg.sv
// Shared definitions for the convolution stream driver: sizes and FSM encoding.
package conv_pkg;

    localparam int NUM_COEFF = 9;
    localparam int PIX_W     = 8;

    // Index of the last coefficient address issued to the ROM.
    localparam logic [3:0] LAST_COEFF = 4'd8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COEFF = 3'd1,
        GAP   = 3'd2,
        PIX   = 3'd3,
        DRAIN = 3'd4
    } drv_state_t;

endpackage

// File: rtl/conv_rd_pipe.sv
// Two-stage read pipeline: read enable becomes a strobe two cycles later, and
// the memory byte (valid one cycle after the read) is captured alongside it.
module conv_rd_pipe
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             re,
    input  logic [PIX_W-1:0] rdata,
    output logic             load,
    output logic [PIX_W-1:0] data
);

    logic valid_r;

    // Delay the read enable by two cycles; latch rdata only while it is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            load    <= 1'b0;
            data    <= {PIX_W{1'b0}};
        end else begin
            valid_r <= re;
            load    <= valid_r;
            if (valid_r) begin
                data <= rdata;
            end else begin
                data <= data;
            end
        end
    end

endmodule

// File: rtl/conv_stream_driver.sv
// Source-side driver for the convolution filter: loads 9 coefficients, then
// streams one raster-ordered frame of pixels, with hold-based back-pressure.
module conv_stream_driver
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int PIX_AW = $clog2(IMG_W*IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [3:0]        coeff_addr,
    output logic              coeff_re,
    input  logic [PIX_W-1:0]  coeff_rdata,
    output logic [PIX_AW-1:0] pix_addr,
    output logic              pix_re,
    input  logic [PIX_W-1:0]  pix_rdata,
    output logic              coeff_load,
    output logic [PIX_W-1:0]  coeff_in,
    output logic              data_load,
    output logic [PIX_W-1:0]  data_i,
    output logic              busy,
    output logic              done
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam logic [CNT_W-1:0] NPIX_C = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NPIX - 1);

    drv_state_t       state_r;
    logic [CNT_W-1:0] issued_r;
    logic [1:0]       drain_r;
    logic             issue_s;
    logic             last_issue_s;

    // Pixel reads follow hold in the same cycle so a stall costs no extra latency.
    always_comb begin
        issue_s      = 1'b0;
        last_issue_s = 1'b0;
        if ((state_r == PIX) && !hold && (issued_r < NPIX_C)) begin
            issue_s      = 1'b1;
            last_issue_s = (issued_r == LAST_C);
        end else begin
            issue_s      = 1'b0;
            last_issue_s = 1'b0;
        end
    end

    assign pix_re = issue_s;

    // Frame sequencing: coefficient burst, one idle gap, pixel stream, drain, done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            coeff_re   <= 1'b0;
            coeff_addr <= 4'd0;
            pix_addr   <= {PIX_AW{1'b0}};
            issued_r   <= {CNT_W{1'b0}};
            drain_r    <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r    <= COEFF;
                        busy       <= 1'b1;
                        coeff_re   <= 1'b1;
                        coeff_addr <= 4'd0;
                        pix_addr   <= {PIX_AW{1'b0}};
                        issued_r   <= {CNT_W{1'b0}};
                        drain_r    <= 2'd0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                COEFF: begin
                    if (coeff_addr == LAST_COEFF) begin
                        coeff_re   <= 1'b0;
                        coeff_addr <= 4'd0;
                        state_r    <= GAP;
                    end else begin
                        coeff_addr <= coeff_addr + 4'd1;
                    end
                end
                GAP: begin
                    state_r <= PIX;
                end
                PIX: begin
                    if (issue_s) begin
                        issued_r <= issued_r + CNT_W'(1);
                        if (last_issue_s) begin
                            state_r <= DRAIN;
                        end else begin
                            pix_addr <= pix_addr + PIX_AW'(1);
                        end
                    end else begin
                        issued_r <= issued_r;
                    end
                end
                DRAIN: begin
                    // Two cycles for the last read to reach the filter, then done.
                    if (drain_r == 2'd2) begin
                        state_r <= IDLE;
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        drain_r <= 2'd0;
                    end else begin
                        drain_r <= drain_r + 2'd1;
                        done    <= (drain_r == 2'd1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    coeff_re <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    conv_rd_pipe u_coeff_pipe (
        .clk   (clk),
        .rst   (rst),
        .re    (coeff_re),
        .rdata (coeff_rdata),
        .load  (coeff_load),
        .data  (coeff_in)
    );

    conv_rd_pipe u_pix_pipe (
        .clk   (clk),
        .rst   (rst),
        .re    (pix_re),
        .rdata (pix_rdata),
        .load  (data_load),
        .data  (data_i)
    );

endmodule

// File: tb/tb_conv_stream_driver.sv
// Self-checking bench for conv_stream_driver: cycle-level reference model built
// from the frame timing rules, plus literal expectations on frame milestones.
module tb_conv_stream_driver;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int N      = IMG_W * IMG_H;
    localparam int PIX_AW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              hold = 1'b0;
    logic [3:0]        coeff_addr;
    logic              coeff_re;
    logic [7:0]        coeff_rdata = 8'd0;
    logic [PIX_AW-1:0] pix_addr;
    logic              pix_re;
    logic [7:0]        pix_rdata = 8'd0;
    logic              coeff_load;
    logic [7:0]        coeff_in;
    logic              data_load;
    logic [7:0]        data_i;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    conv_stream_driver #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_AW(PIX_AW)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .coeff_addr(coeff_addr), .coeff_re(coeff_re), .coeff_rdata(coeff_rdata),
        .pix_addr(pix_addr), .pix_re(pix_re), .pix_rdata(pix_rdata),
        .coeff_load(coeff_load), .coeff_in(coeff_in),
        .data_load(data_load), .data_i(data_i),
        .busy(busy), .done(done)
    );

    logic [7:0] rom [0:8];
    logic [7:0] pmem [0:N-1];

    // Synchronous-read memories: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (coeff_re) coeff_rdata <= rom[coeff_addr];
        if (pix_re)   pix_rdata   <= pmem[pix_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_act = 1'b0;
    int         m_s = 0;
    int         m_iss = 0;
    int         m_done_c = -1;
    bit         cl_at [8];
    logic [7:0] cv_at [8];
    bit         dl_at [8];
    logic [7:0] dv_at [8];
    logic [7:0] m_ci = 8'd0;
    logic [7:0] m_di = 8'd0;
    bit         e_cre, e_pre, e_cl, e_dl, e_done, e_busy;

    // Per-cycle compare of every output against the model's prediction.
    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0; m_done_c = -1; m_ci = 8'd0; m_di = 8'd0;
            for (int i = 0; i < 8; i++) begin cl_at[i] = 1'b0; dl_at[i] = 1'b0; end
            check("rst_coeff_re", 32'(coeff_re), 32'd0);
            check("rst_pix_re", 32'(pix_re), 32'd0);
            check("rst_coeff_addr", 32'(coeff_addr), 32'd0);
            check("rst_pix_addr", 32'(pix_addr), 32'd0);
            check("rst_coeff_load", 32'(coeff_load), 32'd0);
            check("rst_data_load", 32'(data_load), 32'd0);
            check("rst_coeff_in", 32'(coeff_in), 32'd0);
            check("rst_data_i", 32'(data_i), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end else begin
            e_cre = m_act && (cyc >= m_s + 1) && (cyc <= m_s + 9);
            e_pre = m_act && (cyc >= m_s + 11) && !hold && (m_iss < N);
            check("coeff_re", 32'(coeff_re), 32'(e_cre));
            check("pix_re", 32'(pix_re), 32'(e_pre));
            if (e_cre) begin
                check("coeff_addr", 32'(coeff_addr), 32'(cyc - m_s - 1));
                cl_at[(cyc + 2) % 8] = 1'b1;
                cv_at[(cyc + 2) % 8] = rom[cyc - m_s - 1];
            end
            if (e_pre) begin
                check("pix_addr", 32'(pix_addr), 32'(m_iss));
                dl_at[(cyc + 2) % 8] = 1'b1;
                dv_at[(cyc + 2) % 8] = pmem[m_iss];
                m_iss++;
                if (m_iss == N) m_done_c = cyc + 3;
            end
            e_cl = cl_at[cyc % 8];
            if (e_cl) m_ci = cv_at[cyc % 8];
            cl_at[cyc % 8] = 1'b0;
            e_dl = dl_at[cyc % 8];
            if (e_dl) m_di = dv_at[cyc % 8];
            dl_at[cyc % 8] = 1'b0;
            e_done = m_act && (cyc == m_done_c);
            e_busy = m_act && (cyc > m_s);
            check("coeff_load", 32'(coeff_load), 32'(e_cl));
            check("coeff_in", 32'(coeff_in), 32'(m_ci));
            check("data_load", 32'(data_load), 32'(e_dl));
            check("data_i", 32'(data_i), 32'(m_di));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            if (e_done) begin
                m_act = 1'b0;
            end else if (!m_act && start) begin
                m_act = 1'b1; m_s = cyc; m_iss = 0; m_done_c = -1;
            end
        end
    end

    // ---------------- milestone monitor ----------------
    int cl_cnt = 0, dl_cnt = 0, done_cnt = 0;
    int cl_idx = 0, dl_idx = 0;
    int first_cl = 0, last_cl = 0, first_dl = 0, done_at = 0;
    int cseq_bad = 0, seq_bad = 0;

    // Record strobe counts, per-frame ordering and milestone cycles.
    always @(negedge clk) begin
        if (rst) begin
            cl_idx = 0; dl_idx = 0;
        end else begin
            if (coeff_load) begin
                if (cl_idx == 0) first_cl = cyc;
                last_cl = cyc;
                if (coeff_in !== 8'(cl_idx + 1)) cseq_bad++;
                cl_idx++; cl_cnt++;
            end
            if (data_load) begin
                if (dl_idx == 0) first_dl = cyc;
                if (data_i !== 8'(dl_idx)) seq_bad++;
                dl_idx++; dl_cnt++;
            end
            if (done) begin
                done_cnt++; done_at = cyc; cl_idx = 0; dl_idx = 0;
            end
        end
    end

    function automatic logic hold_val(input int mode, input int r);
        case (mode)
            1:       return ((r >= 20) && (r <= 24)) || (r == 40);
            2:       return ($urandom_range(0, 3) == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Drives one frame starting in the current cycle; returns the start cycle.
    task automatic frame(input int mode, input int xs, output int s);
        int d0;
        d0 = done_cnt;
        start = 1'b1; hold = 1'b0; s = cyc;
        for (int r = 1; r < 400 && done_cnt == d0; r++) begin
            @(posedge clk); #1;
            start = (r == xs);
            hold  = hold_val(mode, r);
        end
        start = 1'b0; hold = 1'b0;
        check("frame_done_seen", 32'(done_cnt != d0), 32'd1);
    endtask

    int s, c0, d0, k0, q0;

    initial begin
        for (int i = 0; i < 9; i++) rom[i] = 8'(i + 1);
        for (int i = 0; i < N; i++) pmem[i] = 8'(i);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("idle_no_coeff_load", 32'(cl_cnt), 32'd0);
        check("idle_no_data_load", 32'(dl_cnt), 32'd0);
        check("idle_no_done", 32'(done_cnt), 32'd0);

        // Frame 1: no hold.
        c0 = cl_cnt; d0 = dl_cnt; k0 = cseq_bad; q0 = seq_bad;
        frame(0, -1, s);
        check("f1_coeff_count", 32'(cl_cnt - c0), 32'd9);
        check("f1_first_coeff", 32'(first_cl - s), 32'd3);
        check("f1_last_coeff", 32'(last_cl - s), 32'd11);
        check("f1_coeff_order", 32'(cseq_bad - k0), 32'd0);
        check("f1_first_data", 32'(first_dl - s), 32'd13);
        check("f1_data_count", 32'(dl_cnt - d0), 32'd64);
        check("f1_data_order", 32'(seq_bad - q0), 32'd0);
        check("f1_done_cycle", 32'(done_at - s), 32'd77);

        // Frame 2: hold windows plus a stray start mid-frame; back-to-back start.
        c0 = done_cnt; d0 = dl_cnt; q0 = seq_bad;
        frame(1, 30, s);
        check("f2_single_done", 32'(done_cnt - c0), 32'd1);
        check("f2_data_count", 32'(dl_cnt - d0), 32'd64);
        check("f2_data_order", 32'(seq_bad - q0), 32'd0);
        check("f2_done_cycle", 32'(done_at - s), 32'd83);

        // Frame 3: immediately after done, identical to frame 1.
        d0 = dl_cnt; q0 = seq_bad;
        frame(0, -1, s);
        check("f3_done_cycle", 32'(done_at - s), 32'd77);
        check("f3_data_count", 32'(dl_cnt - d0), 32'd64);
        check("f3_data_order", 32'(seq_bad - q0), 32'd0);

        // Reset mid-PIX, then a fresh frame reloading coefficients.
        @(posedge clk); #1;
        start = 1'b1; s = cyc;
        @(posedge clk); #1; start = 1'b0;
        while (cyc < s + 25) begin @(posedge clk); #1; end
        #1 rst = 1'b1;
        #1;
        check("arst_data_load", 32'(data_load), 32'd0);
        check("arst_pix_re", 32'(pix_re), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_data_i", 32'(data_i), 32'd0);
        check("arst_coeff_in", 32'(coeff_in), 32'd0);
        check("arst_pix_addr", 32'(pix_addr), 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        c0 = cl_cnt; d0 = dl_cnt;
        frame(0, -1, s);
        check("rf_coeff_reload", 32'(cl_cnt - c0), 32'd9);
        check("rf_coeff_before_pix", 32'(first_dl - last_cl), 32'd2);
        check("rf_data_count", 32'(dl_cnt - d0), 32'd64);

        // Randomized frames: random memory contents, holds and stray starts.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 9; i++) rom[i] = 8'($urandom);
            for (int i = 0; i < N; i++) pmem[i] = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            d0 = dl_cnt;
            frame(2, int'($urandom_range(5, 60)), s);
            check("rnd_data_count", 32'(dl_cnt - d0), 32'd64);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
